// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing one transmitter among NREQ sources
// Grants a source for up to BURST words, handshaking each word via vi/snt.
module tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATA_MSB = 7,
  parameter int BURST    = 4
) (
  input  logic                           clk_tx,
  input  logic                           reset,
  input  logic [NREQ-1:0]                src_valid,
  input  logic [NREQ*(DATA_MSB+1)-1:0]   src_data,
  output logic [NREQ-1:0]                src_done,
  output logic [NREQ-1:0]                grant,
  output logic                           vi,
  output logic [DATA_MSB:0]              sdata,
  input  logic                           snt,
  output logic                           busy
);

  localparam int W  = DATA_MSB + 1;
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick;
  logic          found;
  logic [IW:0]   j;
  logic [BW-1:0] burst_cnt;

  // Descending scan so the lowest circular offset from rr_ptr wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = {1'b0, rr_ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
      if (src_valid[j[IW-1:0]]) begin
        pick  = j[IW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_tx or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      vi        <= 1'b0;
      sdata     <= '0;
      src_done  <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      gidx      <= '0;
      burst_cnt <= '0;
    end else begin
      src_done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gidx      <= pick;
            grant     <= ONE << pick;
            sdata     <= src_data[pick*W +: W];
            vi        <= 1'b1;
            burst_cnt <= BW'(1);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (snt) begin
            vi       <= 1'b0;
            src_done <= grant;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          // Source data is sampled only once snt has dropped, giving it time to advance.
          if (!snt) begin
            if (src_valid[gidx] && (burst_cnt < BW'(BURST))) begin
              sdata     <= src_data[gidx*W +: W];
              vi        <= 1'b1;
              burst_cnt <= burst_cnt + 1'b1;
              state     <= SEND;
            end else begin
              rr_ptr    <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
              grant     <= '0;
              burst_cnt <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
